// File: rtl/boundary_analyzer_if.sv
// rtl/boundary_analyzer_if.sv - sample strobe, vector input and polar result bundle
interface boundary_analyzer_if #(
  parameter int WIDTH = 18
);
  logic                    clk_en;
  logic signed [WIDTH-1:0] boundary_x;
  logic signed [WIDTH-1:0] boundary_y;
  logic signed [WIDTH-1:0] magnitude;
  logic signed [WIDTH-1:0] phase;
  logic                    valid;
  logic                    busy;
  logic                    overrun;
  logic                    boundary_active;

  modport master (
    output clk_en, boundary_x, boundary_y,
    input  magnitude, phase, valid, busy, overrun, boundary_active
  );

  modport slave (
    input  clk_en, boundary_x, boundary_y,
    output magnitude, phase, valid, busy, overrun, boundary_active
  );
endinterface

// File: rtl/boundary_analyzer.sv
// rtl/boundary_analyzer.sv - iterative CORDIC vectoring to magnitude/phase with hysteretic activity flag
module boundary_analyzer #(
  parameter int WIDTH      = 18,
  parameter int FRAC       = 14,
  parameter int ITER       = 16,
  parameter int THRESH_ON  = 8192,
  parameter int THRESH_OFF = 4096
) (
  input  logic          clk,
  input  logic          rst,
  boundary_analyzer_if.slave bus
);

  localparam int ZW = WIDTH + 3;
  localparam int PW = ZW + 15;
  localparam logic signed [ZW-1:0] PI_Q      = ZW'(51472);
  localparam logic signed [ZW-1:0] NEG_PI_Q  = -ZW'(51472);
  localparam logic signed [PW-1:0] GAIN_Q    = PW'(9949);
  localparam logic signed [PW-1:0] MAG_MAX   = PW'(2 ** (WIDTH - 1) - 1);
  localparam logic signed [WIDTH-1:0] TH_ON  = WIDTH'(THRESH_ON);
  localparam logic signed [WIDTH-1:0] TH_OFF = WIDTH'(THRESH_OFF);

  typedef enum logic [1:0] {IDLE, ITERATE, DONE} state_t;

  state_t                  state, state_next;
  logic [4:0]              iter_cnt;
  logic signed [ZW-1:0]    x_r, y_r, z_r;
  logic                    zero_in, neg_axis;
  logic signed [WIDTH-1:0] mag_r, phase_r;
  logic                    valid_r, overrun_r, active_r;

  logic                    capture;
  logic                    busy_c;
  logic signed [ZW-1:0]    x_in, y_in, x_pre, y_pre, z_pre;
  logic signed [ZW-1:0]    x_sh, y_sh, atan_c;
  logic signed [PW-1:0]    prod, prod_sh;
  logic signed [WIDTH-1:0] mag_c, phase_c;
  logic signed [ZW-1:0]    z_clamp;

  function automatic logic signed [ZW-1:0] atan_lut(input logic [4:0] i);
    case (i)
      5'd0:    atan_lut = ZW'(12868);
      5'd1:    atan_lut = ZW'(7596);
      5'd2:    atan_lut = ZW'(4014);
      5'd3:    atan_lut = ZW'(2037);
      5'd4:    atan_lut = ZW'(1023);
      5'd5:    atan_lut = ZW'(512);
      5'd6:    atan_lut = ZW'(256);
      5'd7:    atan_lut = ZW'(128);
      5'd8:    atan_lut = ZW'(64);
      5'd9:    atan_lut = ZW'(32);
      5'd10:   atan_lut = ZW'(16);
      5'd11:   atan_lut = ZW'(8);
      5'd12:   atan_lut = ZW'(4);
      5'd13:   atan_lut = ZW'(2);
      5'd14:   atan_lut = ZW'(1);
      5'd15:   atan_lut = ZW'(1);
      default: atan_lut = '0;
    endcase
  endfunction

  // The valid cycle still counts as busy so a strobe there is reported, not silently lost
  assign busy_c  = (state != IDLE) || valid_r;
  assign capture = bus.clk_en && !busy_c;

  // Quadrant pre-rotation into the right half-plane and per-iteration shift terms
  always_comb begin
    x_in  = {{3{bus.boundary_x[WIDTH-1]}}, bus.boundary_x};
    y_in  = {{3{bus.boundary_y[WIDTH-1]}}, bus.boundary_y};
    x_pre = x_in;
    y_pre = y_in;
    z_pre = '0;
    if (x_in[ZW-1]) begin
      x_pre = -x_in;
      y_pre = -y_in;
      z_pre = y_in[ZW-1] ? NEG_PI_Q : PI_Q;
    end
    x_sh   = x_r >>> iter_cnt;
    y_sh   = y_r >>> iter_cnt;
    atan_c = atan_lut(iter_cnt);
  end

  // Gain compensation with saturation, phase clamp and the exact special cases
  always_comb begin
    prod    = {{(PW-ZW){x_r[ZW-1]}}, x_r} * GAIN_Q;
    prod_sh = prod >>> FRAC;
    if (prod_sh > MAG_MAX)   mag_c = MAG_MAX[WIDTH-1:0];
    else if (prod_sh[PW-1])  mag_c = '0;
    else                     mag_c = prod_sh[WIDTH-1:0];
    if (z_r > PI_Q)          z_clamp = PI_Q;
    else if (z_r < NEG_PI_Q) z_clamp = NEG_PI_Q;
    else                     z_clamp = z_r;
    phase_c = z_clamp[WIDTH-1:0];
    if (zero_in) begin
      mag_c   = '0;
      phase_c = '0;
    end else if (neg_axis) begin
      phase_c = PI_Q[WIDTH-1:0];
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (capture) state_next = ITERATE;
      ITERATE: if (iter_cnt == 5'(ITER - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // CORDIC datapath: capture with pre-rotation, then one micro-rotation per clock
  always_ff @(posedge clk) begin
    if (rst) begin
      iter_cnt <= '0;
      x_r      <= '0;
      y_r      <= '0;
      z_r      <= '0;
      zero_in  <= 1'b0;
      neg_axis <= 1'b0;
    end else if (capture) begin
      iter_cnt <= '0;
      x_r      <= x_pre;
      y_r      <= y_pre;
      z_r      <= z_pre;
      zero_in  <= (bus.boundary_x == '0) && (bus.boundary_y == '0);
      neg_axis <= bus.boundary_x[WIDTH-1] && (bus.boundary_y == '0);
    end else if (state == ITERATE) begin
      iter_cnt <= iter_cnt + 5'd1;
      if (!y_r[ZW-1]) begin
        x_r <= x_r + y_sh;
        y_r <= y_r - x_sh;
        z_r <= z_r + atan_c;
      end else begin
        x_r <= x_r - y_sh;
        y_r <= y_r + x_sh;
        z_r <= z_r - atan_c;
      end
    end
  end

  // Result registers, valid/overrun pulses and hysteretic activity flag
  always_ff @(posedge clk) begin
    if (rst) begin
      mag_r     <= '0;
      phase_r   <= '0;
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
      active_r  <= 1'b0;
    end else begin
      valid_r   <= 1'b0;
      overrun_r <= bus.clk_en && busy_c;
      if (state == DONE) begin
        mag_r   <= mag_c;
        phase_r <= phase_c;
        valid_r <= 1'b1;
        if (mag_c >= TH_ON)     active_r <= 1'b1;
        else if (mag_c < TH_OFF) active_r <= 1'b0;
      end
    end
  end

  assign bus.magnitude       = mag_r;
  assign bus.phase           = phase_r;
  assign bus.valid           = valid_r;
  assign bus.busy            = busy_c;
  assign bus.overrun         = overrun_r;
  assign bus.boundary_active = active_r;

endmodule

// File: tb/tb_boundary_analyzer.sv
// tb/tb_boundary_analyzer.sv - table-driven scoreboard bench for boundary_analyzer
module tb_boundary_analyzer;

  typedef struct {
    int x;
    int y;
    int mag;
    int ph;
    int mtol;
    int ptol;
    bit act;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  vec_t vecs[11];
  vec_t sb[$];

  boundary_analyzer_if #(.WIDTH(18)) bus ();

  boundary_analyzer #(
    .WIDTH(18), .FRAC(14), .ITER(16), .THRESH_ON(8192), .THRESH_OFF(4096)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp, input int tol);
    int d;
    n_checks++;
    d = act - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (+/-%0d)", name, act, exp, tol);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " magnitude"}, int'(bus.magnitude), 0, 0);
    check({tag, " phase"}, int'(bus.phase), 0, 0);
    check({tag, " valid"}, int'(bus.valid), 0, 0);
    check({tag, " busy"}, int'(bus.busy), 0, 0);
    check({tag, " overrun"}, int'(bus.overrun), 0, 0);
    check({tag, " active"}, int'(bus.boundary_active), 0, 0);
  endtask

  task automatic convert(input vec_t v, input int ovr_at);
    int   lat;
    int   ovr_seen;
    bit   got;
    vec_t e;
    @(negedge clk);
    bus.boundary_x = 18'(v.x);
    bus.boundary_y = 18'(v.y);
    bus.clk_en     = 1'b1;
    sb.push_back(v);
    lat = 0;
    got = 1'b0;
    ovr_seen = 0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) check("busy after capture", int'(bus.busy), 1, 0);
      if (bus.overrun) ovr_seen++;
      if (bus.valid) got = 1'b1;
      bus.clk_en = (lat == ovr_at);
    end
    bus.clk_en = 1'b0;
    check("valid seen", int'(got), 1, 0);
    e = sb.pop_front();
    if (got) begin
      check("latency", lat, 18, 0);
      check("busy in valid cycle", int'(bus.busy), 1, 0);
      check("magnitude", int'(bus.magnitude), e.mag, e.mtol);
      check("phase", int'(bus.phase), e.ph, e.ptol);
      check("boundary_active", int'(bus.boundary_active), int'(e.act), 0);
    end
    @(negedge clk);
    if (bus.overrun) ovr_seen++;
    check("valid single pulse", int'(bus.valid), 0, 0);
    check("busy after valid", int'(bus.busy), 0, 0);
    check("magnitude hold", int'(bus.magnitude), e.mag, e.mtol);
    @(negedge clk);
    if (bus.overrun) ovr_seen++;
    check("overrun pulses", ovr_seen, (ovr_at > 0) ? 1 : 0, 0);
  endtask

  initial begin
    int   nvalid;
    vec_t v;
    n_checks = 0;
    n_fail   = 0;

    vecs[0]  = '{16384, 0, 16384, 0, 8, 8, 1'b1};
    vecs[1]  = '{0, 16384, 16384, 25736, 8, 8, 1'b1};
    vecs[2]  = '{11585, 11585, 16384, 12868, 8, 8, 1'b1};
    vecs[3]  = '{-16384, 0, 16384, 51472, 8, 0, 1'b1};
    vecs[4]  = '{-16384, -1, 16384, -51472, 8, 8, 1'b1};
    vecs[5]  = '{0, 0, 0, 0, 0, 0, 1'b0};
    vecs[6]  = '{9000, 0, 9000, 0, 8, 8, 1'b1};
    vecs[7]  = '{6000, 0, 6000, 0, 8, 8, 1'b1};
    vecs[8]  = '{3000, 0, 3000, 0, 8, 8, 1'b0};
    vecs[9]  = '{6000, 0, 6000, 0, 8, 8, 1'b0};
    vecs[10] = '{-131072, -131072, 131071, -38604, 0, 8, 1'b1};

    rst = 1'b1;
    bus.clk_en = 1'b0;
    bus.boundary_x = '0;
    bus.boundary_y = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < 11; i++) convert(vecs[i], 0);

    // strobe five cycles into a conversion is dropped and flagged
    v = '{16384, 0, 16384, 0, 8, 8, 1'b1};
    convert(v, 5);

    // reset mid-conversion aborts with no result
    @(negedge clk);
    bus.boundary_x = 18'(9000);
    bus.boundary_y = '0;
    bus.clk_en = 1'b1;
    nvalid = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (bus.valid) nvalid++;
      bus.clk_en = 1'b0;
      rst = (k == 8);
    end
    check("valid after abort", nvalid, 0, 0);
    check_idle_outputs("abort");

    // reset wins over a simultaneous strobe
    rst = 1'b1;
    bus.clk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.clk_en = 1'b0;
    @(negedge clk);
    check("busy after rst+clk_en", int'(bus.busy), 0, 0);

    v = '{0, 16384, 16384, 25736, 8, 8, 1'b1};
    convert(v, 0);

    check("scoreboard empty", sb.size(), 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
